// File: rtl/snn_pkg.sv
// Shared types and helpers for the membrane-potential read-modify-write scheduler.
package snn_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_NUM_NEURONS = 1024;
  localparam int DEF_LEAK_SHIFT  = 3;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWEEP,
    ST_FLUSH
  } state_t;

  // Operation carried through the pipeline: accumulate an event or leak/fire sweep
  typedef enum logic {
    OP_ACC,
    OP_SWEEP
  } op_t;

  // Signed add clamped to the range of a 'width'-bit two's complement number.
  // Operands are sign-extended to 32 bits by the caller; the result fits in 'width' bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] sum;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    sum   = 33'(a) + 33'(b);
    max_v = (33'sd1 <<< (width - 1)) - 33'sd1;
    min_v = -(33'sd1 <<< (width - 1));
    if (sum > max_v) begin
      sat_add = max_v[31:0];
    end else if (sum < min_v) begin
      sat_add = min_v[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/snn_neuron_alu.sv
// Combinational neuron update: saturating accumulate, or leak plus threshold/fire.
module snn_neuron_alu
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  op_t                           op,
  input  logic signed [DATA_WIDTH-1:0]  v,
  input  logic signed [DATA_WIDTH-1:0]  w,
  input  logic signed [DATA_WIDTH-1:0]  threshold,
  output logic signed [DATA_WIDTH-1:0]  new_v,
  output logic                          fire
);

  logic signed [DATA_WIDTH-1:0] leaked;

  // Leak never grows the magnitude, so v - (v >>> k) cannot overflow
  always_comb begin
    leaked = v - (v >>> LEAK_SHIFT);
    new_v  = DATA_WIDTH'(sat_add(32'(v), 32'(w), DATA_WIDTH));
    fire   = 1'b0;
    if (op == OP_SWEEP) begin
      if (leaked >= threshold) begin
        new_v = '0;
        fire  = 1'b1;
      end else begin
        new_v = leaked;
      end
    end
  end

endmodule

// File: rtl/snn_membrane_ctrl.sv
// Membrane-potential RMW scheduler: port A reads (S0), port B writes back (S1).
// A one-entry forward register covers the only hazard: a same-address op in the
// immediately following cycle, whose read happens while the previous write lands.
module snn_membrane_ctrl
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int LEAK_SHIFT  = DEF_LEAK_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_weight,
  input  logic                  step_start,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  mem_ena,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  input  logic [DATA_WIDTH-1:0] mem_doa,
  output logic                  mem_enb,
  output logic                  mem_web,
  output logic [ADDR_WIDTH-1:0] mem_addrb,
  output logic [DATA_WIDTH-1:0] mem_dib,
  output logic                  spike_valid,
  output logic [ADDR_WIDTH-1:0] spike_addr,
  output logic                  step_done,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NEURONS - 1);

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        sweep_cnt_q, sweep_cnt_d;
  logic                         s1_valid_q, s1_valid_d;
  op_t                          s1_op_q, s1_op_d;
  logic [ADDR_WIDTH-1:0]        s1_addr_q, s1_addr_d;
  logic signed [DATA_WIDTH-1:0] s1_w_q, s1_w_d;
  logic                         fwd_valid_q, fwd_valid_d;
  logic [ADDR_WIDTH-1:0]        fwd_addr_q, fwd_addr_d;
  logic signed [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic                         spike_valid_q, spike_valid_d;
  logic [ADDR_WIDTH-1:0]        spike_addr_q, spike_addr_d;
  logic                         step_done_q, step_done_d;

  logic                         accept;
  logic signed [DATA_WIDTH-1:0] operand;
  logic signed [DATA_WIDTH-1:0] alu_new_v;
  logic                         alu_fire;

  // S0 issue and scheduler next-state: events in IDLE, one sweep read per cycle in SWEEP
  always_comb begin
    in_ready    = (state_q == ST_IDLE) && !step_start;
    accept      = in_valid && in_ready;
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    step_done_d = 1'b0;
    mem_ena     = 1'b0;
    mem_addra   = in_addr;
    s1_valid_d  = 1'b0;
    s1_op_d     = OP_ACC;
    s1_addr_d   = in_addr;
    s1_w_d      = $signed(in_weight);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mem_ena    = 1'b1;
          s1_valid_d = 1'b1;
        end
        if (step_start) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q) begin
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        mem_ena    = 1'b1;
        mem_addra  = sweep_cnt_q;
        s1_valid_d = 1'b1;
        s1_op_d    = OP_SWEEP;
        s1_addr_d  = sweep_cnt_q;
        s1_w_d     = '0;
        if (sweep_cnt_q == LAST_ADDR) begin
          sweep_cnt_d = '0;
          state_d     = ST_FLUSH;
        end else begin
          sweep_cnt_d = sweep_cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_FLUSH: begin
        // The last sweep op sits in S1 now; its write lands at this edge
        step_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  snn_neuron_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_alu (
    .op        (s1_op_q),
    .v         (operand),
    .w         (s1_w_q),
    .threshold ($signed(threshold)),
    .new_v     (alu_new_v),
    .fire      (alu_fire)
  );

  // S1 writeback: pick forwarded or memory operand, drive port B, capture forward/spike
  always_comb begin
    if (fwd_valid_q && (fwd_addr_q == s1_addr_q)) begin
      operand = fwd_data_q;
    end else begin
      operand = $signed(mem_doa);
    end
    mem_enb       = s1_valid_q;
    mem_web       = s1_valid_q;
    mem_addrb     = s1_addr_q;
    mem_dib       = alu_new_v;
    fwd_valid_d   = s1_valid_q;
    fwd_addr_d    = s1_addr_q;
    fwd_data_d    = alu_new_v;
    spike_valid_d = s1_valid_q && (s1_op_q == OP_SWEEP) && alu_fire;
    spike_addr_d  = spike_valid_d ? s1_addr_q : spike_addr_q;
  end

  assign spike_valid = spike_valid_q;
  assign spike_addr  = spike_addr_q;
  assign step_done   = step_done_q;
  assign busy        = (state_q != ST_IDLE) || s1_valid_q;

  // State and pipeline registers; reset drops any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sweep_cnt_q   <= '0;
      s1_valid_q    <= 1'b0;
      s1_op_q       <= OP_ACC;
      s1_addr_q     <= '0;
      s1_w_q        <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_addr_q    <= '0;
      fwd_data_q    <= '0;
      spike_valid_q <= 1'b0;
      spike_addr_q  <= '0;
      step_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_cnt_q   <= sweep_cnt_d;
      s1_valid_q    <= s1_valid_d;
      s1_op_q       <= s1_op_d;
      s1_addr_q     <= s1_addr_d;
      s1_w_q        <= s1_w_d;
      fwd_valid_q   <= fwd_valid_d;
      fwd_addr_q    <= fwd_addr_d;
      fwd_data_q    <= fwd_data_d;
      spike_valid_q <= spike_valid_d;
      spike_addr_q  <= spike_addr_d;
      step_done_q   <= step_done_d;
    end
  end

endmodule

// File: tb/tb_snn_membrane_ctrl.sv
// Directed bench for snn_membrane_ctrl with a behavioural dual-port BRAM (read-first).
module tb_snn_membrane_ctrl;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NN = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_weight = '0;
  logic          step_start = 1'b0;
  logic [DW-1:0] threshold = 16'd100;
  logic          mem_ena;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_doa = '0;
  logic          mem_enb;
  logic          mem_web;
  logic [AW-1:0] mem_addrb;
  logic [DW-1:0] mem_dib;
  logic          spike_valid;
  logic [AW-1:0] spike_addr;
  logic          step_done;
  logic          busy;

  // Bench-side preload port into the memory model
  logic          tb_clr = 1'b0;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_data = '0;
  logic [DW-1:0] mem [0:NN-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snn_membrane_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_weight   (in_weight),
    .step_start  (step_start),
    .threshold   (threshold),
    .mem_ena     (mem_ena),
    .mem_addra   (mem_addra),
    .mem_doa     (mem_doa),
    .mem_enb     (mem_enb),
    .mem_web     (mem_web),
    .mem_addrb   (mem_addrb),
    .mem_dib     (mem_dib),
    .spike_valid (spike_valid),
    .spike_addr  (spike_addr),
    .step_done   (step_done),
    .busy        (busy)
  );

  // True dual-port BRAM: registered read on A, write on B, old data on collision
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < NN; i++) mem[i] <= '0;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (mem_enb && mem_web) begin
      mem[mem_addrb] <= mem_dib;
    end
    if (mem_ena) mem_doa <= mem[mem_addra];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic poke(input int a, input int d);
    tb_addr = AW'(a);
    tb_data = DW'(d);
    tb_we   = 1'b1;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  typedef struct packed {
    logic          v;
    logic [AW-1:0] addr;
    logic [DW-1:0] w;
    logic          e_ena;
    logic [AW-1:0] e_addra;
    logic          e_web;
    logic [AW-1:0] e_addrb;
    logic [DW-1:0] e_dib;
  } vec_t;

  function automatic vec_t mk(input logic v, input int a, input int w, input logic e_ena,
                              input int e_addra, input logic e_web, input int e_addrb,
                              input int e_dib);
    vec_t r;
    r.v = v;         r.addr = AW'(a);       r.w = DW'(w);
    r.e_ena = e_ena; r.e_addra = AW'(e_addra);
    r.e_web = e_web; r.e_addrb = AW'(e_addrb); r.e_dib = DW'(e_dib);
    return r;
  endfunction

  // Hand-computed writebacks of the sweep (threshold 100, leak v - v>>>3)
  function automatic logic [DW-1:0] sweep_exp(input int a);
    case (a)
      0:       return 16'd70;    // event 80 -> 80 - 10
      9:       return 16'd44;    // 50 - 6
      11:      return 16'hFFD5;  // -50 - (-7) = -43
      default: return 16'd0;     // includes addr 2 (fired) and untouched zeros
    endcase
  endfunction

  vec_t vecs[12];

  initial begin
    int nxt, spikes, prev_wr, quiet_bad;
    bit done, prev_last, done_after_last, ready_ok, spike_after_w2, hit;
    logic [AW-1:0] spk_a;

    vecs[0]  = mk(1, 5,   40,    1, 5, 0, 0, 0);
    vecs[1]  = mk(1, 7,   10,    1, 7, 1, 5, 40);
    vecs[2]  = mk(1, 7,   20,    1, 7, 1, 7, 10);
    vecs[3]  = mk(1, 7,   30,    1, 7, 1, 7, 30);
    vecs[4]  = mk(1, 3,   1000,  1, 3, 1, 7, 60);
    vecs[5]  = mk(1, 4,   -1000, 1, 4, 1, 3, 32767);
    vecs[6]  = mk(0, 0,   0,     0, 0, 1, 4, -32768);
    vecs[7]  = mk(1, 5,   2,     1, 5, 0, 0, 0);
    vecs[8]  = mk(1, 7,   -100,  1, 7, 1, 5, 42);
    vecs[9]  = mk(1, 5,   1,     1, 5, 1, 7, -40);
    vecs[10] = mk(0, 0,   0,     0, 0, 1, 5, 43);
    vecs[11] = mk(0, 0,   0,     0, 0, 0, 0, 0);

    // Reset state
    tb_clr = 1'b1;
    repeat (2) @(negedge clk);
    tb_clr = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_web", mem_web, 0);
    check("rst_mem_enb", mem_enb, 0);
    check("rst_mem_ena", mem_ena, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_step_done", step_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    poke(3, 32000);
    poke(4, -32000);

    // Accumulate vectors: issue, forwarding and saturation
    for (int i = 0; i < 12; i++) begin
      in_valid  = vecs[i].v;
      in_addr   = vecs[i].addr;
      in_weight = vecs[i].w;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      check($sformatf("v%0d_mem_ena", i), mem_ena, vecs[i].e_ena);
      if (vecs[i].e_ena) check($sformatf("v%0d_mem_addra", i), mem_addra, vecs[i].e_addra);
      check($sformatf("v%0d_mem_web", i), mem_web, vecs[i].e_web);
      check($sformatf("v%0d_mem_enb", i), mem_enb, vecs[i].e_web);
      if (vecs[i].e_web) begin
        check($sformatf("v%0d_mem_addrb", i), mem_addrb, vecs[i].e_addrb);
        check($sformatf("v%0d_mem_dib", i), mem_dib, vecs[i].e_dib);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Sweep setup: memory 0 except 2=120, 9=50, 11=-50
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
    poke(2, 120);
    poke(9, 50);
    poke(11, -50);

    // Event the cycle before step_start; a second event alongside step_start is refused
    in_valid = 1'b1; in_addr = 10'd0; in_weight = 16'd80;
    #1;
    check("pre_step_ready", in_ready, 1);
    check("pre_step_ena", mem_ena, 1);
    @(negedge clk);
    step_start = 1'b1; in_addr = 10'd20; in_weight = 16'd5;
    #1;
    check("step_in_ready", in_ready, 0);
    check("step_no_accept", mem_ena, 0);
    check("step_event_web", mem_web, 1);
    check("step_event_addrb", mem_addrb, 0);
    check("step_event_dib", mem_dib, 80);
    @(negedge clk);
    step_start = 1'b0; in_valid = 1'b0;

    nxt = 0; spikes = 0; prev_wr = -1; spk_a = '0;
    done = 0; prev_last = 0; done_after_last = 0; ready_ok = 1; spike_after_w2 = 0;
    for (int c = 0; c < 1200 && !done; c++) begin
      #1;
      if (step_done) begin
        done = 1; done_after_last = prev_last;
      end else if (in_ready) begin
        ready_ok = 0;
      end
      if (spike_valid) begin
        spikes++; spk_a = spike_addr; spike_after_w2 = (prev_wr == 2);
      end
      prev_last = mem_web && (mem_addrb == AW'(NN - 1));
      if (mem_web) begin
        check("sweep_addrb", 32'(mem_addrb), nxt);
        check("sweep_dib", mem_dib, sweep_exp(nxt));
        prev_wr = int'(mem_addrb);
        nxt++;
      end else begin
        prev_wr = -1;
      end
      @(negedge clk);
    end
    check("sweep_done_seen", done, 1);
    check("sweep_write_count", nxt, NN);
    check("sweep_done_after_last", done_after_last, 1);
    check("sweep_spike_count", spikes, 1);
    check("sweep_spike_addr", spk_a, 2);
    check("sweep_spike_timing", spike_after_w2, 1);
    check("sweep_ready_low", ready_ok, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("post_step_done", step_done, 0);
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
      @(negedge clk);
    end

    // Reset mid-sweep at addr 500 with a spike (addr 498) and a write (addr 499) in flight
    poke(498, 120);
    poke(499, 50);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 700 && !hit; c++) begin
      #1;
      if (mem_ena && mem_addra == 10'd500) hit = 1;
      else @(negedge clk);
    end
    check("mid_reached_500", hit, 1);
    check("mid_spike_before_rst", spike_valid, 1);
    check("mid_web_before_rst", mem_web, 1);
    check("mid_addrb_before_rst", mem_addrb, 499);
    rst_n = 1'b0;
    #1;
    check("mid_rst_web", mem_web, 0);
    check("mid_rst_spike", spike_valid, 0);
    check("mid_rst_step_done", step_done, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_bad = 0;
    for (int c = 0; c < 1100; c++) begin
      #1;
      if (step_done || spike_valid || mem_web) quiet_bad++;
      @(negedge clk);
    end
    #1;
    check("after_rst_quiet", quiet_bad, 0);
    check("after_rst_in_ready", in_ready, 1);
    check("after_rst_busy", busy, 0);
    check("after_rst_write_dropped", mem[499], 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
